// File: rtl/regwb_pkg.sv
// Shared types and helpers for the register-file writeback sequencer.
package regwb_pkg;

  localparam int TID_W       = 2;
  localparam int NUM_THREADS = 4;
  localparam int WB_D_W      = 64;

  typedef struct packed {
    logic [WB_D_W-1:0] data;
    logic [4:0]        rd;
    logic [TID_W-1:0]  tid;
  } wb_entry_t;

  function automatic logic [NUM_THREADS-1:0] tid2onehot(input logic [TID_W-1:0] tid);
    logic [NUM_THREADS-1:0] oh;
    oh      = '0;
    oh[tid] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-source result FIFO; head visible the cycle after push, pop is same-cycle.
// full = !ready: a full FIFO ignores push even when popped in the same cycle.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit tells a wrapped (full) state apart from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/regwb_seq.sv
// Writeback sequencer: ALU and load results -> one register-file write per cycle, accept-to-ctrl_WB 2 cycles.
// ready = !full per source; mem wins contention unless ALU starved STARVE_MAX times. Option: REGWB_BYPASS_EN.
module regwb_seq
  import regwb_pkg::*;
#(
  parameter int D_WIDTH    = WB_D_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [D_WIDTH-1:0]     alu_data,
  input  logic [4:0]             alu_rd,
  input  logic [TID_W-1:0]       alu_tid,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [D_WIDTH-1:0]     mem_data,
  input  logic [4:0]             mem_rd,
  input  logic [TID_W-1:0]       mem_tid,
  output logic                   ctrl_WB,
  output logic [D_WIDTH-1:0]     data_WB,
  output logic [4:0]             reg_wraddr,
  output logic [NUM_THREADS-1:0] thread_sel_WB,
  output logic                   idle
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [4:0]             rs1_ID,
  input  logic [4:0]             rs2_ID,
  input  logic [NUM_THREADS-1:0] thread_sel_ID,
  output logic                   byp1_hit,
  output logic                   byp2_hit
`endif
);

  localparam int E_W  = $bits(wb_entry_t);
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  wb_entry_t       alu_in, mem_in, alu_head, mem_head, win;
  logic            alu_full, alu_empty, mem_full, mem_empty;
  logic            grant_alu, grant_mem, grant;
  logic [SC_W-1:0] starve_cnt;

  assign alu_in    = '{data: alu_data, rd: alu_rd, tid: alu_tid};
  assign mem_in    = '{data: mem_data, rd: mem_rd, tid: mem_tid};
  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  wb_fifo #(.W(E_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (alu_valid && alu_ready),
    .push_dat (alu_in),
    .pop      (grant_alu),
    .full     (alu_full),
    .empty    (alu_empty),
    .head     (alu_head)
  );

  wb_fifo #(.W(E_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (mem_valid && mem_ready),
    .push_dat (mem_in),
    .pop      (grant_mem),
    .full     (mem_full),
    .empty    (mem_empty),
    .head     (mem_head)
  );

  // Loads normally win; a saturated starve count hands the slot to the ALU.
  assign grant_alu = !alu_empty && (mem_empty || (starve_cnt == SC_W'(STARVE_MAX)));
  assign grant_mem = !mem_empty && !grant_alu;
  assign grant     = grant_alu || grant_mem;
  assign win       = grant_alu ? alu_head : mem_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!alu_empty && !grant_alu) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // x0 entries still consume the slot and load data/addr, but never write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_WB       <= 1'b0;
      data_WB       <= '0;
      reg_wraddr    <= '0;
      thread_sel_WB <= '0;
    end else if (grant) begin
      ctrl_WB       <= (win.rd != 5'd0);
      data_WB       <= win.data;
      reg_wraddr    <= win.rd;
      thread_sel_WB <= (win.rd != 5'd0) ? tid2onehot(win.tid) : '0;
    end else begin
      ctrl_WB       <= 1'b0;
      thread_sel_WB <= '0;
    end
  end

  assign idle = alu_empty && mem_empty && !ctrl_WB;

`ifdef REGWB_BYPASS_EN
  assign byp1_hit = ctrl_WB && (thread_sel_WB == thread_sel_ID) && (reg_wraddr == rs1_ID);
  assign byp2_hit = ctrl_WB && (thread_sel_WB == thread_sel_ID) && (reg_wraddr == rs2_ID);
`endif

endmodule

// File: tb/tb_regwb_seq.sv
// Directed bench for regwb_seq: reset, latency, x0, arbitration, backpressure, reset flush, bypass.
module tb_regwb_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [63:0] alu_data, mem_data, data_WB;
  logic [4:0]  alu_rd, mem_rd, reg_wraddr;
  logic [1:0]  alu_tid, mem_tid;
  logic        ctrl_WB, idle;
  logic [3:0]  thread_sel_WB;
`ifdef REGWB_BYPASS_EN
  logic [4:0]  rs1_ID, rs2_ID;
  logic [3:0]  thread_sel_ID;
  logic        byp1_hit, byp2_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regwb_seq dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_data      (alu_data),
    .alu_rd        (alu_rd),
    .alu_tid       (alu_tid),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data),
    .mem_rd        (mem_rd),
    .mem_tid       (mem_tid),
    .ctrl_WB       (ctrl_WB),
    .data_WB       (data_WB),
    .reg_wraddr    (reg_wraddr),
    .thread_sel_WB (thread_sel_WB),
    .idle          (idle)
`ifdef REGWB_BYPASS_EN
    ,
    .rs1_ID        (rs1_ID),
    .rs2_ID        (rs2_ID),
    .thread_sel_ID (thread_sel_ID),
    .byp1_hit      (byp1_hit),
    .byp2_hit      (byp2_hit)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int          na, nm, nw, ai, mi, acnt;
  logic        acc_a, acc_m, saw_full;
  logic [63:0] agot [8];

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_data = '0; alu_rd = '0; alu_tid = '0;
    mem_valid = 1'b0; mem_data = '0; mem_rd = '0; mem_tid = '0;
`ifdef REGWB_BYPASS_EN
    rs1_ID = '0; rs2_ID = '0; thread_sel_ID = '0;
`endif
    tick(); tick();
    reset = 1'b0;

    chk("rst_ctrl", 64'(ctrl_WB), 64'd0);
    chk("rst_data", data_WB, 64'd0);
    chk("rst_addr", 64'(reg_wraddr), 64'd0);
    chk("rst_tsel", 64'(thread_sel_WB), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_alu_rdy", 64'(alu_ready), 64'd1);
    chk("rst_mem_rdy", 64'(mem_ready), 64'd1);

    // Single ALU write: accept edge, +1 edge grant, +2 edge ctrl_WB
    alu_valid = 1'b1; alu_data = 64'h1234; alu_rd = 5'd5; alu_tid = 2'd2;
    tick();
    alu_valid = 1'b0;
    chk("lat_c1_ctrl", 64'(ctrl_WB), 64'd0);
    chk("lat_c1_idle", 64'(idle), 64'd0);
    tick();
    chk("alu_ctrl", 64'(ctrl_WB), 64'd1);
    chk("alu_addr", 64'(reg_wraddr), 64'd5);
    chk("alu_tsel", 64'(thread_sel_WB), 64'b0100);
    chk("alu_data", data_WB, 64'h1234);
    tick();
    chk("alu_pulse", 64'(ctrl_WB), 64'd0);
    chk("alu_idle", 64'(idle), 64'd1);
    chk("alu_tsel_clr", 64'(thread_sel_WB), 64'd0);
    chk("alu_data_hold", data_WB, 64'h1234);

    // x0 suppression
    mem_valid = 1'b1; mem_data = 64'hABCD; mem_rd = 5'd0; mem_tid = 2'd1;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("x0_ctrl", 64'(ctrl_WB), 64'd0);
    chk("x0_tsel", 64'(thread_sel_WB), 64'd0);
    chk("x0_data_loaded", data_WB, 64'hABCD);
    tick();
    chk("x0_ctrl2", 64'(ctrl_WB), 64'd0);
    chk("x0_mem_rdy", 64'(mem_ready), 64'd1);
    chk("x0_idle", 64'(idle), 64'd1);

    // Contention: both stream; expect mem x4, alu, repeating
    ai = 0; mi = 0; na = 0; nm = 0; nw = 0; acc_a = 0; acc_m = 0;
    for (int cyc = 0; cyc < 40 && nw < 15; cyc++) begin
      alu_valid = 1'b1; alu_data = 64'hA000 + 64'(ai); alu_rd = 5'd10; alu_tid = 2'd1;
      mem_valid = 1'b1; mem_data = 64'hB000 + 64'(mi); mem_rd = 5'd20; mem_tid = 2'd2;
      if (ctrl_WB) begin
        if (nw % 5 == 4) begin
          chk("arb_alu_addr", 64'(reg_wraddr), 64'd10);
          chk("arb_alu_data", data_WB, 64'hA000 + 64'(na));
          chk("arb_alu_tsel", 64'(thread_sel_WB), 64'b0010);
          na++;
        end else begin
          chk("arb_mem_addr", 64'(reg_wraddr), 64'd20);
          chk("arb_mem_data", data_WB, 64'hB000 + 64'(nm));
          nm++;
        end
        nw++;
      end
      acc_a = alu_ready; acc_m = mem_ready;
      tick();
      if (acc_a) ai++;
      if (acc_m) mi++;
    end
    chk("arb_write_count", 64'(nw), 64'd15);
    drain(8);
    chk("arb_drain_idle", 64'(idle), 64'd1);

    // Backpressure: three held ALU entries under mem pressure
    ai = 0; mi = 0; acnt = 0; saw_full = 1'b0; acc_a = 0; acc_m = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      alu_valid = (ai < 3); alu_data = 64'hC000 + 64'(ai); alu_rd = 5'd3; alu_tid = 2'd0;
      mem_valid = (cyc < 12); mem_data = 64'hD000 + 64'(mi); mem_rd = 5'd9; mem_tid = 2'd3;
      if (alu_valid && !alu_ready) saw_full = 1'b1;
      if (ctrl_WB && reg_wraddr == 5'd3) begin
        if (acnt < 8) agot[acnt] = data_WB;
        acnt++;
      end
      acc_a = alu_valid && alu_ready; acc_m = mem_valid && mem_ready;
      tick();
      if (acc_a) ai++;
      if (acc_m) mi++;
    end
    chk("bp_alu_full_seen", 64'(saw_full), 64'd1);
    chk("bp_alu_count", 64'(acnt), 64'd3);
    if (acnt >= 3) begin
      chk("bp_alu0", agot[0], 64'hC000);
      chk("bp_alu1", agot[1], 64'hC001);
      chk("bp_alu2", agot[2], 64'hC002);
    end
    chk("bp_idle", 64'(idle), 64'd1);

    // Reset mid-stream discards buffered results
    alu_valid = 1'b1; alu_data = 64'hE0; alu_rd = 5'd4; alu_tid = 2'd0;
    mem_valid = 1'b1; mem_data = 64'hF0; mem_rd = 5'd6; mem_tid = 2'd1;
    tick(); tick(); tick();
    chk("mid_busy", 64'(idle), 64'd0);
    alu_valid = 1'b0; mem_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ctrl", 64'(ctrl_WB), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    chk("mid_rst_alu_rdy", 64'(alu_ready), 64'd1);
    chk("mid_rst_mem_rdy", 64'(mem_ready), 64'd1);
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ctrl_WB) nw++;
    end
    chk("mid_no_stale", 64'(nw), 64'd0);

`ifdef REGWB_BYPASS_EN
    rs1_ID = 5'd7; rs2_ID = 5'd8; thread_sel_ID = 4'b1000;
    alu_valid = 1'b1; alu_data = 64'h77; alu_rd = 5'd7; alu_tid = 2'd3;
    tick();
    alu_valid = 1'b0;
    chk("byp_before", 64'(byp1_hit), 64'd0);
    tick();
    chk("byp1_hit", 64'(byp1_hit), 64'd1);
    chk("byp2_miss", 64'(byp2_hit), 64'd0);
    tick();
    chk("byp_after", 64'(byp1_hit), 64'd0);
    thread_sel_ID = 4'b0001;
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("byp_thr_ctrl", 64'(ctrl_WB), 64'd1);
    chk("byp_thr_miss", 64'(byp1_hit), 64'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
